multicycle_controller: RTL and testbench

Main control FSM for the multicycle RV32I core: sequences the shared ALU, memory port, instruction register and register file over several cycles per instruction. It drives the immediate-format select consumed by the `sign_extend` block and the ALU operation code. Supported instructions are lw, sw, R-type ALU, I-type ALU and beq. Any other opcode is flagged and skipped.

---
 rtl/multicycle_controller_if.sv | 32 +++
 rtl/multicycle_controller.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32I datapath and its main FSM.
// The datapath (master) supplies instruction fields and Zero; the controller (slave) returns the control strobes.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal, State
    );

    modport slave (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, Illegal, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core (lw, sw, R/I-type ALU, beq).
// Control outputs are registered together with the state, so they always match the state register.
module multicycle_controller (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_controller_if.slave        bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t     r_state;
    logic       r_pc_write;
    logic       r_adr_src;
    logic       r_mem_write;
    logic       r_ir_write;
    logic       r_reg_write;
    logic       r_branch;
    logic [1:0] r_result_src;
    logic [1:0] r_alu_src_a;
    logic [1:0] r_alu_src_b;
    logic [1:0] r_alu_op;

    state_t     w_next_state;
    logic       w_pc_write;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_branch;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_supported;
    logic [2:0] w_alu_control;
    logic [1:0] w_imm_src;

    assign w_supported = (bus.op == OP_LW) || (bus.op == OP_SW) || (bus.op == OP_R) ||
                         (bus.op == OP_I)  || (bus.op == OP_BEQ);

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:   w_next_state = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECR;
                    OP_I:         w_next_state = S_EXECI;
                    OP_BEQ:       w_next_state = S_BEQ;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next_state = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: w_next_state = S_MEMWB;
            S_EXECR,
            S_EXECI:   w_next_state = S_ALUWB;
            default:   w_next_state = S_FETCH;
        endcase

        // Outputs are decoded for the state being entered and registered alongside it.
        w_pc_write   = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_branch     = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        case (w_next_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_pc_write   = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
            end
            S_MEMREAD: w_adr_src = 1'b1;
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b10;
            end
            S_EXECI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
            end
            S_ALUWB: w_reg_write = 1'b1;
            S_BEQ: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b01;
                w_branch    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_FETCH;
            r_pc_write   <= 1'b1;
            r_adr_src    <= 1'b0;
            r_mem_write  <= 1'b0;
            r_ir_write   <= 1'b1;
            r_reg_write  <= 1'b0;
            r_branch     <= 1'b0;
            r_result_src <= 2'b10;
            r_alu_src_a  <= 2'b00;
            r_alu_src_b  <= 2'b10;
            r_alu_op     <= 2'b00;
        end else begin
            r_state      <= w_next_state;
            r_pc_write   <= w_pc_write;
            r_adr_src    <= w_adr_src;
            r_mem_write  <= w_mem_write;
            r_ir_write   <= w_ir_write;
            r_reg_write  <= w_reg_write;
            r_branch     <= w_branch;
            r_result_src <= w_result_src;
            r_alu_src_a  <= w_alu_src_a;
            r_alu_src_b  <= w_alu_src_b;
            r_alu_op     <= w_alu_op;
        end
    end

    always_comb begin
        w_alu_control = 3'b000;
        case (r_alu_op)
            2'b01: w_alu_control = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  w_alu_control = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  w_alu_control = 3'b101;
                    3'b110:  w_alu_control = 3'b011;
                    3'b111:  w_alu_control = 3'b010;
                    default: w_alu_control = 3'b000;
                endcase
            end
            default: w_alu_control = 3'b000;
        endcase
    end

    always_comb begin
        w_imm_src = 2'b00;
        if (bus.op == OP_SW)
            w_imm_src = 2'b01;
        else if (bus.op == OP_BEQ)
            w_imm_src = 2'b10;
    end

    // PC and IR enables are held off while reset is high even though the state already reads FETCH.
    assign bus.PCWrite    = ~reset & (r_pc_write | (r_branch & bus.Zero));
    assign bus.IRWrite    = ~reset & r_ir_write;
    assign bus.AdrSrc     = r_adr_src;
    assign bus.MemWrite   = r_mem_write;
    assign bus.RegWrite   = r_reg_write;
    assign bus.ResultSrc  = r_result_src;
    assign bus.ALUSrcA    = r_alu_src_a;
    assign bus.ALUSrcB    = r_alu_src_b;
    assign bus.ALUControl = w_alu_control;
    assign bus.ImmSrc     = w_imm_src;
    assign bus.Illegal    = (r_state == S_DECODE) & ~w_supported;
    assign bus.State      = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: the driver pushes per-cycle expected
// control vectors from an instruction-level model; a negedge monitor pops and compares them.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic       regw;
        logic [1:0] rsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [2:0] aluc;
        logic [1:0] imm;
        logic       ill;
    } ctl_t;

    ctl_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   final_chk = 1'b0;

    function automatic bit supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_I) || (op == OP_BEQ);
    endfunction

    // Arithmetic result the instruction asks for, by RV32I mnemonic.
    function automatic logic [2:0] arith_code(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (op == OP_R && f7) ? 3'b001 : 3'b000; // sub vs add/addi
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic ctl_t model_cycle(input int st, input logic [6:0] op, input logic [2:0] f3,
                                         input logic f7, input logic z);
        ctl_t c;
        c = '0;
        c.st  = 4'(st);
        c.imm = (op == OP_SW) ? 2'b01 : (op == OP_BEQ) ? 2'b10 : 2'b00;
        case (st)
            0: begin c.pcw = 1; c.irw = 1; c.srcb = 2'b10; c.rsrc = 2'b10; end
            1: begin c.srca = 2'b01; c.srcb = 2'b01; c.ill = !supported(op); end
            2: begin c.srca = 2'b10; c.srcb = 2'b01; end
            3: begin c.adr = 1; end
            4: begin c.rsrc = 2'b01; c.regw = 1; end
            5: begin c.adr = 1; c.memw = 1; end
            6: begin c.srca = 2'b10; c.aluc = arith_code(op, f3, f7); end
            7: begin c.srca = 2'b10; c.srcb = 2'b01; c.aluc = arith_code(op, f3, f7); end
            8: begin c.regw = 1; end
            9: begin c.srca = 2'b10; c.aluc = 3'b001; c.pcw = z; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t observe();
        ctl_t c;
        c.st   = bus.State;
        c.pcw  = bus.PCWrite;
        c.adr  = bus.AdrSrc;
        c.memw = bus.MemWrite;
        c.irw  = bus.IRWrite;
        c.regw = bus.RegWrite;
        c.rsrc = bus.ResultSrc;
        c.srca = bus.ALUSrcA;
        c.srcb = bus.ALUSrcB;
        c.aluc = bus.ALUControl;
        c.imm  = bus.ImmSrc;
        c.ill  = bus.Illegal;
        return c;
    endfunction

    function automatic ctl_t reset_cycle(input logic [6:0] op);
        ctl_t c;
        c = model_cycle(0, op, 3'b000, 1'b0, 1'b0);
        c.pcw = 1'b0;
        c.irw = 1'b0;
        return c;
    endfunction

    task automatic drive_fields(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.Zero     = z;
    endtask

    // Called just after the edge that enters FETCH; returns just after the edge that re-enters FETCH.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        int seq[$];
        drive_fields(op, f3, f7, z);
        case (op)
            OP_LW:   seq = '{0, 1, 2, 3, 4};
            OP_SW:   seq = '{0, 1, 2, 5};
            OP_R:    seq = '{0, 1, 6, 8};
            OP_I:    seq = '{0, 1, 7, 8};
            OP_BEQ:  seq = '{0, 1, 9};
            default: seq = '{0, 1};
        endcase
        foreach (seq[k]) exp_q.push_back(model_cycle(seq[k], op, f3, f7, z));
        repeat (seq.size()) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        ctl_t a;
        ctl_t e;
        cyc <= cyc + 1;
        if (mon_en) begin
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL ctl_underflow cyc=%0d act_state=%0d exp=queue entry", cyc, bus.State);
            end else begin
                e = exp_q.pop_front();
                a = observe();
                if (a !== e) begin
                    bad = bad + 1;
                    $display("FAIL ctl_vec cyc=%0d act_state=%0d exp_state=%0d act=%h exp=%h",
                             cyc, a.st, e.st, a, e);
                end
            end
        end
        if (final_chk) begin
            total = total + 1;
            if (exp_q.size() != 0) begin
                bad = bad + 1;
                $display("FAIL leftover act=%0d exp=0", exp_q.size());
            end
        end
    end

    initial begin
        logic [6:0] op;
        reset = 1'b1;
        drive_fields(OP_R, 3'b000, 1'b1, 1'b0);
        repeat (3) exp_q.push_back(reset_cycle(OP_R));
        mon_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(OP_LW,  3'b010, 1'b0, 1'b0);
        run_instr(OP_SW,  3'b010, 1'b1, 1'b1);
        run_instr(OP_R,   3'b000, 1'b1, 1'b0);
        run_instr(OP_I,   3'b000, 1'b1, 1'b0);
        run_instr(OP_R,   3'b010, 1'b0, 1'b0);
        run_instr(OP_R,   3'b111, 1'b0, 1'b1);
        run_instr(OP_I,   3'b110, 1'b0, 1'b0);
        run_instr(OP_BEQ, 3'b000, 1'b0, 1'b1);
        run_instr(OP_BEQ, 3'b000, 1'b0, 1'b0);
        run_instr(OP_JAL, 3'b000, 1'b0, 1'b1);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 5))
                0: op = OP_LW;
                1: op = OP_SW;
                2: op = OP_R;
                3: op = OP_I;
                4: op = OP_BEQ;
                default: begin
                    op = 7'($urandom);
                    if (supported(op)) op = OP_JAL;
                end
            endcase
            run_instr(op, 3'($urandom), 1'($urandom), 1'($urandom));
        end

        // Reset asserted right after entering EXECR: the next sample must already read FETCH.
        drive_fields(OP_R, 3'b000, 1'b1, 1'b1);
        exp_q.push_back(model_cycle(0, OP_R, 3'b000, 1'b1, 1'b1));
        exp_q.push_back(model_cycle(1, OP_R, 3'b000, 1'b1, 1'b1));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) exp_q.push_back(reset_cycle(OP_R));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        run_instr(OP_SW, 3'b000, 1'b0, 1'b1);
        run_instr(OP_LW, 3'b000, 1'b0, 1'b0);

        mon_en = 1'b0;
        final_chk = 1'b1;
        @(negedge clk);
        #1;
        final_chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
